// File: rtl/mem_bus.sv
// Single-port memory/I-O slave: word RAM, UART transmitter with a 4-deep FIFO,
// free-running cycle timer and LED register. Reads return one cycle after ren.
module mem_bus #(
    parameter int    RAM_WORDS = 4096,
    parameter string INIT_FILE = "",
    parameter int    CLK_DIV   = 104
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ren,
    input  logic [15:0] addr,
    output logic [31:0] rdata,
    output logic        rd_valid,
    input  logic        wen,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    output logic        uart_tx,
    output logic [7:0]  led
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int BW = $clog2(CLK_DIV);
    localparam logic [BW-1:0] RELOAD = BW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic          is_ram, is_io, rd_go, stat_rd;
    logic [1:0]    sel;
    logic [AW-1:0] widx;
    logic [31:0]   rd_mux, timer;
    logic          unused_ok;

    assign is_ram    = {16'd0, addr} < 32'(RAM_WORDS * 4);
    assign is_io     = addr[15];
    assign sel       = addr[3:2];
    assign widx      = addr[AW+1:2];
    assign rd_go     = ren && !wen;
    assign stat_rd   = rd_go && is_io && sel == 2'd1;
    assign unused_ok = &{1'b0, addr};

    // RAM: no reset, per-lane write enables (wmask[3] is the low byte)
    logic [31:0] ram [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (!rst && wen && is_ram)
            for (int i = 0; i < 4; i++)
                if (wmask[3-i]) ram[widx][8*i +: 8] <= wdata[8*i +: 8];
    end

    // UART FIFO
    logic [7:0] fifo [4];
    logic [1:0] wp, rp;
    logic [2:0] cnt;
    logic       ovf, push, pop, full, empty, accept;

    assign full   = cnt == 3'd4;
    assign empty  = cnt == 3'd0;
    assign push   = wen && is_io && sel == 2'd0;
    assign accept = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (!rst && accept) fifo[wp] <= wdata[7:0];
    end

    // UART transmitter FSM
    state_t        state, state_nxt;
    logic [BW-1:0] baud, baud_nxt;
    logic [2:0]    bitn, bitn_nxt;
    logic [7:0]    shreg;

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud;
        bitn_nxt  = bitn;
        pop       = 1'b0;
        uart_tx   = 1'b1;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_nxt = START;
                    baud_nxt  = RELOAD;
                    pop       = 1'b1;
                end
            end
            START: begin
                uart_tx = 1'b0;
                if (baud == '0) begin
                    state_nxt = DATA;
                    baud_nxt  = RELOAD;
                    bitn_nxt  = 3'd0;
                end else begin
                    baud_nxt = baud - 1'b1;
                end
            end
            DATA: begin
                uart_tx = shreg[bitn];
                if (baud == '0) begin
                    baud_nxt = RELOAD;
                    if (bitn == 3'd7) state_nxt = STOP;
                    else              bitn_nxt  = bitn + 3'd1;
                end else begin
                    baud_nxt = baud - 1'b1;
                end
            end
            STOP: begin
                if (baud == '0) state_nxt = IDLE;
                else            baud_nxt  = baud - 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        if (is_ram) begin
            rd_mux = ram[widx];
        end else if (is_io) begin
            case (sel)
                2'd1:    rd_mux = {28'd0, empty, ovf, state != IDLE, full};
                2'd2:    rd_mux = timer;
                2'd3:    rd_mux = {24'd0, led};
                default: rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud     <= '0;
            bitn     <= '0;
            shreg    <= '0;
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            timer    <= '0;
            led      <= '0;
            rdata    <= '0;
            rd_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            baud  <= baud_nxt;
            bitn  <= bitn_nxt;
            if (pop) begin
                shreg <= fifo[rp];
                rp    <= rp + 2'd1;
            end
            if (accept) wp <= wp + 2'd1;
            cnt <= cnt + {2'd0, accept} - {2'd0, pop};
            // a fresh overflow outranks the clear from a status read
            if (push && full && !pop) ovf <= 1'b1;
            else if (stat_rd)         ovf <= 1'b0;
            timer <= timer + 32'd1;
            if (wen && is_io && sel == 2'd3 && wmask[3]) led <= wdata[7:0];
            rd_valid <= rd_go;
            if (rd_go) rdata <= rd_mux;
        end
    end
endmodule

// File: tb/tb_mem_bus.sv
// Bench for mem_bus: directed vector table, randomized RAM/LED traffic against a
// word-array model, UART frame decoding, FIFO overflow, timer and reset corners.
module tb_mem_bus;
    localparam int RAM_WORDS = 1024;
    localparam int CLK_DIV   = 4;

    logic        clk = 1'b0, rst = 1'b1, ren = 1'b0, wen = 1'b0;
    logic [15:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wmask = '0;
    logic [31:0] rdata;
    logic        rd_valid, uart_tx;
    logic [7:0]  led;

    int vecs = 0, errs = 0;
    logic mon_en = 1'b1;
    logic [7:0] rx_q[$];

    mem_bus #(.RAM_WORDS(RAM_WORDS), .INIT_FILE(""), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .ren(ren), .addr(addr), .rdata(rdata),
        .rd_valid(rd_valid), .wen(wen), .wdata(wdata), .wmask(wmask),
        .uart_tx(uart_tx), .led(led)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic r; logic w; logic [15:0] a; logic [31:0] d; logic [3:0] m;
        logic ev; logic [31:0] er;
    } vec_t;

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [15:0] a,
                         input logic [31:0] d, input logic [3:0] m);
        ren = r; wen = w; addr = a; wdata = d; wmask = m;
    endtask

    function automatic vec_t mk(input logic r, input logic w, input logic [15:0] a,
                                input logic [31:0] d, input logic [3:0] m,
                                input logic ev, input logic [31:0] er);
        vec_t v;
        v.r = r; v.w = w; v.a = a; v.d = d; v.m = m; v.ev = ev; v.er = er;
        return v;
    endfunction

    // UART receiver: samples each bit at its first cycle, queues decoded bytes
    initial begin
        logic [7:0] b;
        forever begin
            step();
            if (mon_en && uart_tx === 1'b0) begin
                for (int k = 0; k < 8; k++) begin
                    repeat (CLK_DIV) step();
                    b[k] = uart_tx;
                end
                repeat (CLK_DIV) step();
                chk("stop_bit", {31'd0, uart_tx}, 32'd1);
                rx_q.push_back(b);
            end
        end
    end

    initial begin
        vec_t        tbl[$];
        logic [31:0] mem_m [16];
        logic [7:0]  led_m;
        logic [31:0] rdata_m, d, rv [4];
        logic [15:0] a;
        logic [3:0]  m, w4;
        logic        r, wr, ev, tx_low, wrap_ok;
        int          op;
        int          exp_bits [10];

        // ---- reset state
        repeat (3) step();
        rst = 1'b0;
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        chk("rst_led", {24'd0, led}, 32'd0);

        // ---- directed vectors: one row per cycle, response checked after the edge
        tbl.push_back(mk(0, 1, 16'h0010, 32'h11223344, 4'b1111, 0, 32'h0));
        tbl.push_back(mk(0, 1, 16'h0011, 32'h0000AA00, 4'b0100, 0, 32'h0));
        tbl.push_back(mk(1, 0, 16'h0010, 32'h0, 4'b0000, 1, 32'h1122AA44));
        tbl.push_back(mk(0, 0, 16'h0000, 32'h0, 4'b0000, 0, 32'h1122AA44));
        tbl.push_back(mk(0, 1, 16'h0000, 32'hDEADBEEF, 4'b1111, 0, 32'h1122AA44));
        tbl.push_back(mk(1, 0, 16'h0000, 32'h0, 4'b0000, 1, 32'hDEADBEEF));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 0, 16'h0000, 32'h0, 4'b0000, 0, 32'hDEADBEEF));
        tbl.push_back(mk(1, 0, 16'h7000, 32'h0, 4'b0000, 1, 32'h0));
        tbl.push_back(mk(0, 1, 16'h800C, 32'h000001FF, 4'b1000, 0, 32'h0));
        tbl.push_back(mk(1, 0, 16'h800C, 32'h0, 4'b0000, 1, 32'h000000FF));
        tbl.push_back(mk(1, 1, 16'h0000, 32'h12345678, 4'b0001, 0, 32'h000000FF));
        tbl.push_back(mk(1, 0, 16'h0000, 32'h0, 4'b0000, 1, 32'h12ADBEEF));
        tbl.push_back(mk(0, 1, 16'h1000, 32'hFFFFFFFF, 4'b1111, 0, 32'h12ADBEEF));
        tbl.push_back(mk(1, 0, 16'h1000, 32'h0, 4'b0000, 1, 32'h0));
        tbl.push_back(mk(0, 1, 16'h0000, 32'h0, 4'b0000, 0, 32'h0));
        tbl.push_back(mk(1, 0, 16'h0002, 32'h0, 4'b0000, 1, 32'h12ADBEEF));
        tbl.push_back(mk(0, 1, 16'h800C, 32'h00000077, 4'b0111, 0, 32'h12ADBEEF));
        tbl.push_back(mk(1, 0, 16'h800C, 32'h0, 4'b0000, 1, 32'h000000FF));
        tbl.push_back(mk(1, 0, 16'h9004, 32'h0, 4'b0000, 1, 32'h00000008));
        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].m);
            step();
            chk($sformatf("tbl%0d_valid", i), {31'd0, rd_valid}, {31'd0, tbl[i].ev});
            chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].er);
        end

        // ---- randomized RAM / LED / unmapped traffic against a word-array model
        led_m   = 8'hFF;
        rdata_m = 32'h8;
        for (int i = 0; i < 16; i++) begin
            mem_m[i] = $urandom;
            drive(0, 1, 16'(i * 4), mem_m[i], 4'b1111);
            step();
            chk("init_valid", {31'd0, rd_valid}, 32'd0);
        end
        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 5);
            w4 = 4'($urandom_range(0, 15));
            r = 0; wr = 0; d = $urandom; m = 4'($urandom_range(0, 15));
            a = {10'd0, w4, 2'($urandom_range(0, 3))};
            case (op)
                0: r = 1;
                1: wr = 1;
                2: begin r = 1; a = 16'h1000 + 16'($urandom_range(0, 16'h6FFF)); end
                3: begin wr = 1; r = 1'($urandom_range(0, 1));
                         a = 16'h800C | (16'($urandom) & 16'h7FF0); end
                4: begin r = 1; a = 16'h800C | (16'($urandom) & 16'h7FF0); end
                default: begin r = 1; wr = 1; end
            endcase
            ev = r && !wr;
            if (ev) begin
                if (a < 16'h1000)  rdata_m = mem_m[a[5:2]];
                else if (a[15])    rdata_m = {24'd0, led_m};
                else               rdata_m = 32'd0;
            end
            if (wr && a < 16'h1000)
                for (int i = 0; i < 4; i++)
                    if (m[3-i]) mem_m[a[5:2]][8*i +: 8] = d[8*i +: 8];
            if (wr && a[15] && a[3:2] == 2'd3 && m[3]) led_m = d[7:0];
            drive(r, wr, a, d, m);
            step();
            chk("rnd_valid", {31'd0, rd_valid}, {31'd0, ev});
            chk("rnd_rdata", rdata, rdata_m);
            chk("rnd_led", {24'd0, led}, {24'd0, led_m});
        end

        // ---- single UART frame: 0xA5, start bit two cycles after the push
        exp_bits = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        drive(0, 1, 16'h8000, 32'hFFFFFFA5, 4'b0000);
        step();
        drive(0, 0, 16'h0, 32'h0, 4'b0000);
        step();
        for (int j = 0; j < 10 * CLK_DIV; j++) begin
            if (j == 8) drive(1, 0, 16'h8004, 32'h0, 4'b0000);
            else        drive(0, 0, 16'h0, 32'h0, 4'b0000);
            chk($sformatf("tx_cyc%0d", j), {31'd0, uart_tx}, 32'(exp_bits[j / CLK_DIV]));
            if (j == 9) chk("stat_busy", rdata, 32'hA);
            step();
        end
        chk("tx_idle", {31'd0, uart_tx}, 32'd1);
        drive(1, 0, 16'h8004, 32'h0, 4'b0000);
        step();
        drive(0, 0, 16'h0, 32'h0, 4'b0000);
        chk("stat_after", rdata, 32'h8);
        chk("rx_count1", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) chk("rx_byte_a5", {24'd0, rx_q[0]}, 32'hA5);
        rx_q.delete();

        // ---- FIFO overflow: 6 back-to-back pushes, 5 frames expected
        for (int k = 0; k < 6; k++) begin
            drive(0, 1, 16'h8000, 32'(8'h31 + k), 4'b1111);
            step();
        end
        drive(1, 0, 16'h8004, 32'h0, 4'b0000);
        step();
        chk("stat_ovf", rdata, 32'h7);
        step();
        chk("stat_reread", rdata, 32'h3);
        drive(0, 0, 16'h0, 32'h0, 4'b0000);
        repeat (6 * 11 * CLK_DIV + 40) step();
        chk("rx_count5", 32'(rx_q.size()), 32'd5);
        for (int k = 0; k < 5 && k < rx_q.size(); k++)
            chk($sformatf("rx_byte%0d", k), {24'd0, rx_q[k]}, 32'(8'h31 + k));
        rx_q.delete();

        // ---- reset in the middle of a frame, with a second byte queued
        mon_en = 1'b0;
        drive(0, 1, 16'h800C, 32'h5A, 4'b1000);
        step();
        drive(0, 1, 16'h8000, 32'h77, 4'b1111);
        step();
        drive(0, 1, 16'h8000, 32'h88, 4'b1111);
        step();
        drive(0, 0, 16'h0, 32'h0, 4'b0000);
        repeat (3 * CLK_DIV) step();
        chk("led_pre_rst", {24'd0, led}, 32'h5A);
        rst = 1'b1;
        drive(1, 0, 16'h8004, 32'h0, 4'b0000);
        step();
        rst = 1'b0;
        drive(0, 0, 16'h0, 32'h0, 4'b0000);
        chk("midrst_tx", {31'd0, uart_tx}, 32'd1);
        chk("midrst_valid", {31'd0, rd_valid}, 32'd0);
        chk("midrst_led", {24'd0, led}, 32'd0);
        tx_low = 1'b0;
        for (int j = 0; j < 12 * CLK_DIV; j++) begin
            if (uart_tx !== 1'b1) tx_low = 1'b1;
            step();
        end
        chk("midrst_tx_quiet", {31'd0, tx_low}, 32'd0);
        drive(1, 0, 16'h8004, 32'h0, 4'b0000);
        step();
        chk("midrst_stat", rdata, 32'h8);
        drive(0, 1, 16'h800C, 32'h1FF, 4'b1000);
        step();
        drive(1, 0, 16'h800C, 32'h0, 4'b0000);
        step();
        drive(0, 0, 16'h0, 32'h0, 4'b0000);
        chk("led_rd", rdata, 32'h000000FF);
        chk("led_out", {24'd0, led}, 32'hFF);

        // ---- timer: read in cycle T+10 after the last reset edge T returns 10
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst2_rdata", rdata, 32'd0);
        repeat (10) step();
        drive(1, 0, 16'h8008, 32'h0, 4'b0000);
        step();
        drive(0, 0, 16'h0, 32'h0, 4'b0000);
        chk("timer_10", rdata, 32'd10);

        // ---- timer wrap: preload all-ones, a later read must follow it with 0
        force dut.timer = 32'hFFFFFFFF;
        drive(1, 0, 16'h8008, 32'h0, 4'b0000);
        step();
        release dut.timer;
        rv[0] = rdata;
        for (int k = 1; k < 4; k++) begin
            step();
            rv[k] = rdata;
        end
        drive(0, 0, 16'h0, 32'h0, 4'b0000);
        wrap_ok = 1'b0;
        for (int k = 0; k < 3; k++)
            if (rv[k] == 32'hFFFFFFFF && rv[k+1] == 32'd0) wrap_ok = 1'b1;
        chk("timer_wrap", {31'd0, wrap_ok}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
